// File: rtl/out_port_pkg.sv
// Shared types and constants for the serial output port transmitter.
// Holds the FSM state encoding and the frame line levels.
package out_port_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

endpackage

// File: rtl/out_port_fifo.sv
// Byte FIFO feeding the transmitter; pointers carry one extra wrap bit
// so that full and empty are distinguishable without a separate count.
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic                 push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the cleared pointers mark every slot as empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/out_port_tx.sv
// Buffered serial transmitter for the CPU output port: start, 8 data bits
// LSB first, optional even parity (OUT_PORT_TX_PARITY_EN), stop.
module out_port_tx
  import out_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  state_e               state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;
  logic                 pop, push, bit_done;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  out_port_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_data),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A write seen while full is lost even if a pop frees a slot at that edge.
  assign push     = wr_en && !fifo_full;
  assign ovf_d    = ovf_q || (wr_en && fifo_full);
  assign bit_done = (div_q == 8'(CLKS_PER_BIT - 1));

  assign full     = fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign overflow = ovf_q;
  assign tx       = tx_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    idx_d   = idx_q;
    byte_d  = byte_q;
    pop     = 1'b0;
    tx_d    = STOP_LVL;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          byte_d  = fifo_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          div_d   = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          div_d = '0;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef OUT_PORT_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef OUT_PORT_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          div_d   = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          div_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            byte_d  = fifo_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        div_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // The line is registered, so it is driven from the state being entered.
    case (state_d)
      ST_START:  tx_d = START_LVL;
      ST_DATA:   tx_d = byte_d[idx_d];
`ifdef OUT_PORT_TX_PARITY_EN
      ST_PARITY: tx_d = ^byte_d;
`endif
      default:   tx_d = STOP_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      tx_q    <= STOP_LVL;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_out_port_tx.sv
// Self-checking bench for out_port_tx: directed frame scenarios plus random
// writes, checked every cycle against a frame-level behavioural model.
module tb_out_port_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef OUT_PORT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst, wr_en;
  logic [7:0] wr_data;
  logic       full, busy, overflow, tx;

  int checks = 0;
  int errors = 0;

  out_port_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue and the frame currently on the line,
  // expressed as a bit list and a cycle offset into it.
  logic [7:0]  mq[$];
  bit          m_active;
  int          m_t;
  logic [10:0] m_frame;
  bit          m_ovf;

  logic rec_tx [0:511];
  int   rec_n, busy_n;

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef OUT_PORT_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  pre;
    bit  frame_end;
    if (!rst) begin
      mq.delete();
      m_active = 0;
      m_t      = 0;
      m_ovf    = 0;
    end else begin
      pre       = mq.size();
      frame_end = m_active && (m_t == FL - 1);
      if (!m_active || frame_end) begin
        m_t = 0;
        if (pre > 0) begin
          m_frame  = frame_bits(mq.pop_front());
          m_active = 1;
        end else begin
          m_active = 0;
        end
      end else begin
        m_t++;
      end
      if (wr_en) begin
        if (pre == DEPTH) m_ovf = 1;
        else mq.push_back(wr_data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("tx",       tx,       m_active ? m_frame[m_t / CPB] : 1'b1);
    chk("busy",     busy,     m_active || (mq.size() > 0));
    chk("full",     full,     mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    if (rec_n < 512) rec_tx[rec_n] = tx;
    rec_n++;
    if (busy) busy_n++;
  endtask

  task automatic rec_start();
    rec_n  = 0;
    busy_n = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && busy; i++) tick();
    chk("drain_timeout", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [7:0] bytes6 [6];
  logic [7:0] dec;
  logic [10:0] fexp;
  int   ones;
  bit   found;

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rec_start();

    // Reset state
    do_reset();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);

    // Single byte 0x05
    wr_en = 1'b1; wr_data = 8'h05;
    tick();
    wr_en = 1'b0;
    rec_start();
    repeat (FL + 8) tick();
    chk("b05_busy_cycles", 16'(busy_n), 16'(FL));
    fexp = frame_bits(8'h05);
    chk("b05_frame_nopar", fexp[9:0], 10'b1000001010);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < CPB; c++)
        chk("b05_bit", rec_tx[b * CPB + c], fexp[b]);
    chk("b05_idle_after", rec_tx[FL], 1'b1);

    // Back-to-back 0xA5, 0x3C
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    rec_start();
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    repeat (2 * FL + 8) tick();
    chk("b2b_busy_cycles", 16'(busy_n), 16'(2 * FL));
    chk("b2b_stop_last", rec_tx[FL - 1], 1'b1);
    chk("b2b_start_next", rec_tx[FL], 1'b0);
    for (int k = 0; k < 2; k++) begin
      dec = '0;
      for (int b = 0; b < 8; b++) dec[b] = rec_tx[k * FL + (b + 1) * CPB + CPB / 2];
      chk("b2b_byte", dec, (k == 0) ? 8'hA5 : 8'h3C);
    end

    // Six consecutive writes into a 4-deep FIFO
    for (int i = 0; i < 6; i++) bytes6[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = bytes6[i];
      tick();
      if (i == 0) rec_start();
      if (i == 4) chk("ovf6_full", full, 1'b1);
    end
    wr_en = 1'b0;
    chk("ovf6_flag", overflow, 1'b1);
    repeat (5 * FL + 20) tick();
    chk("ovf6_busy_cycles", 16'(busy_n), 16'(5 * FL));
    for (int k = 0; k < 5; k++) begin
      dec = '0;
      for (int b = 0; b < 8; b++) dec[b] = rec_tx[k * FL + (b + 1) * CPB + CPB / 2];
      chk("ovf6_byte", dec, bytes6[k]);
      chk("ovf6_start", rec_tx[k * FL + CPB / 2], 1'b0);
    end
    chk("ovf6_sticky", overflow, 1'b1);

    // Reset in the middle of frame 0xFF, with a write at the reset edge
    do_reset();
    chk("rst2_ovf_clear", overflow, 1'b0);
    wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    rec_start();
    repeat (4 * CPB + 2) tick();
    chk("abort_mid_bit3", tx, 1'b1);
    rst = 1'b0; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_full", full, 1'b0);
    rst = 1'b1; wr_en = 1'b0;
    rec_start();
    ones = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx === 1'b1) ones++;
    end
    chk("abort_no_frame_busy", 16'(busy_n), 16'd0);
    chk("abort_no_frame_tx", 16'(ones), 16'd60);

    // Write while full, landing on a STOP-to-START pop
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_active && (m_t == FL - 1) && (mq.size() > 0)) found = 1;
      else tick();
    end
    chk("sync_found", found, 1'b1);
    chk("sync_pre_full", full, 1'b1);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    chk("sync_ovf", overflow, 1'b1);
    chk("sync_not_full", full, 1'b0);
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    chk("sync_occ3_refill", full, 1'b1);
    drain();

`ifdef OUT_PORT_TX_PARITY_EN
    // Parity frames
    do_reset();
    wr_en = 1'b1; wr_data = 8'h07;
    tick();
    wr_en = 1'b0;
    rec_start();
    repeat (FL + 8) tick();
    chk("par07_busy", 16'(busy_n), 16'd44);
    chk("par07_bit", rec_tx[9 * CPB + CPB / 2], 1'b1);
    wr_en = 1'b1; wr_data = 8'h03;
    tick();
    wr_en = 1'b0;
    rec_start();
    repeat (FL + 8) tick();
    chk("par03_bit", rec_tx[9 * CPB + CPB / 2], 1'b0);
`endif

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 299) != 0);
      wr_en   = ($urandom_range(0, 11) == 0) || (i > 400 && i < 420);
      wr_data = 8'($urandom);
      tick();
    end
    rst = 1'b1; wr_en = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
